// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - mode encodings, BCD limits and BCD increment helper for time_keeper
package clock_pkg;

  typedef enum logic [2:0] {
    MODE_RUN               = 3'd0,
    MODE_SET_HOURS         = 3'd1,
    MODE_SET_MINUTES       = 3'd2,
    MODE_SET_ALARM_HOURS   = 3'd3,
    MODE_SET_ALARM_MINUTES = 3'd4
  } mode_t;

  localparam int HOURS_MODULUS   = 24;
  localparam int MINUTES_MODULUS = 60;
  localparam int SECONDS_MODULUS = 60;

  // Next two-digit BCD value modulo i_modulus; anything at or past the top wraps to 00
  function automatic logic [7:0] bcd_next(input logic [3:0] i_tens, input logic [3:0] i_ones,
                                          input int i_modulus);
    int v;
    v = int'(i_tens) * 10 + int'(i_ones);
    if (v >= i_modulus - 1)
      return 8'h00;
    else if (i_ones >= 4'd9)
      return {i_tens + 4'd1, 4'd0};
    else
      return {i_tens, i_ones + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - two-digit BCD counter with modulus, increment, clear and carry-out
module bcd_counter
  import clock_pkg::*;
#(
  parameter int MODULUS     = 60,
  parameter int TENS_W      = 3,
  parameter int RESET_VALUE = 0
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Inc,
  input  logic              i_Clear,
  output logic [TENS_W-1:0] o_Tens,
  output logic [3:0]        o_Ones,
  output logic              o_Carry
);

  localparam logic [3:0] RST_TENS = 4'(RESET_VALUE / 10);
  localparam logic [3:0] RST_ONES = 4'(RESET_VALUE % 10);

  logic [TENS_W-1:0] r_Tens;
  logic [3:0]        r_Ones;
  logic [7:0]        w_Next;
  logic              w_At_Max;

  assign w_Next   = bcd_next(4'(r_Tens), r_Ones, MODULUS);
  assign w_At_Max = (int'(r_Tens) * 10 + int'(r_Ones)) == (MODULUS - 1);
  assign o_Carry  = i_Inc & w_At_Max;
  assign o_Tens   = r_Tens;
  assign o_Ones   = r_Ones;

  // Digit registers: clear wins over increment so a mode exit always lands on 00
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Tens <= TENS_W'(RST_TENS);
      r_Ones <= RST_ONES;
    end else if (i_Clear) begin
      r_Tens <= '0;
      r_Ones <= '0;
    end else if (i_Inc) begin
      r_Tens <= TENS_W'(w_Next[7:4]);
      r_Ones <= w_Next[3:0];
    end
  end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD 24h clock with set modes; alarm built only with TIME_KEEPER_ALARM_EN
module time_keeper
  import clock_pkg::*;
#(
  parameter int RESET_HOURS   = 0,
  parameter int RESET_MINUTES = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Enable_1Hz,
  input  logic       i_Button_Mode,
  input  logic       i_Button_Inc,
  output logic [1:0] o_Hours_Tens,
  output logic [3:0] o_Hours_Ones,
  output logic [2:0] o_Minutes_Tens,
  output logic [3:0] o_Minutes_Ones,
  output logic [2:0] o_Seconds_Tens,
  output logic [3:0] o_Seconds_Ones,
  output logic [2:0] o_Mode
`ifdef TIME_KEEPER_ALARM_EN
  ,
  output logic       o_Alarm
`endif
);

  mode_t r_State, w_Next_State;
  logic  w_Mode_Step, w_Run_Tick, w_Inc_Allowed;
  logic  w_Set_Hours_Inc, w_Set_Minutes_Inc, w_Clear_Seconds;
  logic  w_Sec_Carry, w_Min_Carry, w_Hour_Carry_unused;
  logic  w_Min_Inc, w_Hour_Inc;

`ifdef TIME_KEEPER_ALARM_EN
  logic       r_Alarm;
  logic       w_Set_Alarm_Hours_Inc, w_Set_Alarm_Minutes_Inc, w_Alarm_Match;
  logic       w_Alarm_Hour_Carry_unused, w_Alarm_Min_Carry_unused;
  logic [1:0] w_Alarm_Hours_Tens;
  logic [3:0] w_Alarm_Hours_Ones;
  logic [2:0] w_Alarm_Minutes_Tens;
  logic [3:0] w_Alarm_Minutes_Ones;
  logic [7:0] w_Next_Minutes, w_Next_Hours;

  // A mode press while the alarm rings only silences it
  assign w_Mode_Step = i_Button_Mode & ~r_Alarm;
`else
  assign w_Mode_Step = i_Button_Mode;
`endif

  // Mode state register
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) r_State <= MODE_RUN;
    else            r_State <= w_Next_State;
  end

  // Next-state: one step per accepted mode pulse
  always_comb begin
    w_Next_State = r_State;
    if (w_Mode_Step) begin
      case (r_State)
        MODE_RUN:               w_Next_State = MODE_SET_HOURS;
        MODE_SET_HOURS:         w_Next_State = MODE_SET_MINUTES;
`ifdef TIME_KEEPER_ALARM_EN
        MODE_SET_MINUTES:       w_Next_State = MODE_SET_ALARM_HOURS;
        MODE_SET_ALARM_HOURS:   w_Next_State = MODE_SET_ALARM_MINUTES;
        MODE_SET_ALARM_MINUTES: w_Next_State = MODE_RUN;
`else
        MODE_SET_MINUTES:       w_Next_State = MODE_RUN;
`endif
        default:                w_Next_State = MODE_RUN;
      endcase
    end
  end

  // Per-state controls; an increment coinciding with a mode pulse is dropped
  always_comb begin
    o_Mode            = r_State;
    w_Run_Tick        = (r_State == MODE_RUN) & i_Enable_1Hz;
    w_Inc_Allowed     = i_Button_Inc & ~i_Button_Mode;
    w_Set_Hours_Inc   = (r_State == MODE_SET_HOURS) & w_Inc_Allowed;
    w_Set_Minutes_Inc = (r_State == MODE_SET_MINUTES) & w_Inc_Allowed;
    w_Clear_Seconds   = (r_State == MODE_SET_MINUTES) & w_Mode_Step;
`ifdef TIME_KEEPER_ALARM_EN
    w_Set_Alarm_Hours_Inc   = (r_State == MODE_SET_ALARM_HOURS) & w_Inc_Allowed;
    w_Set_Alarm_Minutes_Inc = (r_State == MODE_SET_ALARM_MINUTES) & w_Inc_Allowed;
`endif
  end

  // Minute carry reaches hours only while running, never from a set-mode increment
  assign w_Min_Inc  = w_Sec_Carry | w_Set_Minutes_Inc;
  assign w_Hour_Inc = (w_Min_Carry & w_Run_Tick) | w_Set_Hours_Inc;

  bcd_counter #(.MODULUS(SECONDS_MODULUS), .TENS_W(3), .RESET_VALUE(0)) u_seconds (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Inc(w_Run_Tick), .i_Clear(w_Clear_Seconds),
    .o_Tens(o_Seconds_Tens), .o_Ones(o_Seconds_Ones), .o_Carry(w_Sec_Carry));

  bcd_counter #(.MODULUS(MINUTES_MODULUS), .TENS_W(3), .RESET_VALUE(RESET_MINUTES)) u_minutes (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Inc(w_Min_Inc), .i_Clear(1'b0),
    .o_Tens(o_Minutes_Tens), .o_Ones(o_Minutes_Ones), .o_Carry(w_Min_Carry));

  bcd_counter #(.MODULUS(HOURS_MODULUS), .TENS_W(2), .RESET_VALUE(RESET_HOURS)) u_hours (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Inc(w_Hour_Inc), .i_Clear(1'b0),
    .o_Tens(o_Hours_Tens), .o_Ones(o_Hours_Ones), .o_Carry(w_Hour_Carry_unused));

`ifdef TIME_KEEPER_ALARM_EN
  bcd_counter #(.MODULUS(HOURS_MODULUS), .TENS_W(2), .RESET_VALUE(0)) u_alarm_hours (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Inc(w_Set_Alarm_Hours_Inc), .i_Clear(1'b0),
    .o_Tens(w_Alarm_Hours_Tens), .o_Ones(w_Alarm_Hours_Ones), .o_Carry(w_Alarm_Hour_Carry_unused));

  bcd_counter #(.MODULUS(MINUTES_MODULUS), .TENS_W(3), .RESET_VALUE(0)) u_alarm_minutes (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Inc(w_Set_Alarm_Minutes_Inc), .i_Clear(1'b0),
    .o_Tens(w_Alarm_Minutes_Tens), .o_Ones(w_Alarm_Minutes_Ones), .o_Carry(w_Alarm_Min_Carry_unused));

  // HH:MM the current seconds carry is about to produce
  assign w_Next_Minutes = bcd_next(4'(o_Minutes_Tens), o_Minutes_Ones, MINUTES_MODULUS);
  assign w_Next_Hours   = (w_Next_Minutes == 8'h00)
                        ? bcd_next(4'(o_Hours_Tens), o_Hours_Ones, HOURS_MODULUS)
                        : {4'(o_Hours_Tens), o_Hours_Ones};
  assign w_Alarm_Match  = (w_Next_Hours == {4'(w_Alarm_Hours_Tens), w_Alarm_Hours_Ones})
                        & (w_Next_Minutes == {4'(w_Alarm_Minutes_Tens), w_Alarm_Minutes_Ones});

  // Alarm flag: raised by the tick that lands on HH:MM:00, dropped by the next mode press
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n)                      r_Alarm <= 1'b0;
    else if (i_Button_Mode & r_Alarm)    r_Alarm <= 1'b0;
    else if (w_Sec_Carry & w_Alarm_Match) r_Alarm <= 1'b1;
  end

  assign o_Alarm = r_Alarm;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper
module tb_time_keeper;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;

  logic [1:0] ht_a, ht_b;
  logic [3:0] ho_a, ho_b, mo_a, mo_b, so_a, so_b;
  logic [2:0] mt_a, mt_b, st_a, st_b, mode_a, mode_b;
  logic [23:0] time_a, time_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign time_a = {2'b00, ht_a, ho_a, 1'b0, mt_a, mo_a, 1'b0, st_a, so_a};
  assign time_b = {2'b00, ht_b, ho_b, 1'b0, mt_b, mo_b, 1'b0, st_b, so_b};

`ifdef TIME_KEEPER_ALARM_EN
  logic alarm_a, alarm_b;
  localparam logic [2:0] MODE_AFTER_SET_MIN = 3'd3;
`else
  localparam logic [2:0] MODE_AFTER_SET_MIN = 3'd0;
`endif

  time_keeper dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable_1Hz(tick),
    .i_Button_Mode(btn_mode), .i_Button_Inc(btn_inc),
    .o_Hours_Tens(ht_a), .o_Hours_Ones(ho_a), .o_Minutes_Tens(mt_a), .o_Minutes_Ones(mo_a),
    .o_Seconds_Tens(st_a), .o_Seconds_Ones(so_a), .o_Mode(mode_a)
`ifdef TIME_KEEPER_ALARM_EN
    , .o_Alarm(alarm_a)
`endif
  );

  time_keeper #(.RESET_HOURS(23), .RESET_MINUTES(59)) dut_pre (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable_1Hz(tick),
    .i_Button_Mode(btn_mode), .i_Button_Inc(btn_inc),
    .o_Hours_Tens(ht_b), .o_Hours_Ones(ho_b), .o_Minutes_Tens(mt_b), .o_Minutes_Ones(mo_b),
    .o_Seconds_Tens(st_b), .o_Seconds_Ones(so_b), .o_Mode(mode_b)
`ifdef TIME_KEEPER_ALARM_EN
    , .o_Alarm(alarm_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs starting at a negedge; returns at the next negedge
  task automatic step(input logic t, input logic m, input logic i);
    tick = t; btn_mode = m; btn_inc = i;
    @(negedge clk);
    tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_time", 32'(time_a), 32'h000000);
    check("reset_mode", 32'(mode_a), 32'd0);
    check("reset_pre_time", 32'(time_b), 32'h235900);
`ifdef TIME_KEEPER_ALARM_EN
    check("reset_alarm", 32'(alarm_a), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_hold", 32'(time_a), 32'h000000);

    repeat (58) step(1'b1, 1'b0, 1'b0);
    check("pre_58", 32'(time_b), 32'h235958);
    step(1'b1, 1'b0, 1'b0);
    check("tick_59", 32'(time_a), 32'h000059);
    check("pre_59", 32'(time_b), 32'h235959);
    step(1'b1, 1'b0, 1'b0);
    check("tick_60", 32'(time_a), 32'h000100);
    check("pre_wrap", 32'(time_b), 32'h000000);
`ifdef TIME_KEEPER_ALARM_EN
    check("pre_alarm_midnight", 32'(alarm_b), 32'd1);
`endif

    step(1'b0, 1'b0, 1'b1);
    check("inc_in_run", 32'(time_a), 32'h000100);
    repeat (37) step(1'b1, 1'b0, 1'b0);
    check("ss_37", 32'(time_a), 32'h000137);

    step(1'b0, 1'b1, 1'b1);
    check("mode_inc_mode", 32'(mode_a), 32'd1);
    check("mode_inc_time", 32'(time_a), 32'h000137);
    repeat (25) step(1'b0, 1'b0, 1'b1);
    check("hours_x25", 32'(time_a), 32'h010137);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("frozen", 32'(time_a), 32'h010137);

    step(1'b0, 1'b1, 1'b0);
    check("mode_set_min", 32'(mode_a), 32'd2);
    repeat (59) step(1'b0, 1'b0, 1'b1);
    check("min_wrap_nocarry", 32'(time_a), 32'h010037);
    step(1'b0, 1'b1, 1'b0);
    check("exit_mode", 32'(mode_a), 32'(MODE_AFTER_SET_MIN));
    check("exit_ss_clear", 32'(time_a), 32'h010000);
`ifdef TIME_KEEPER_ALARM_EN
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("back_to_run", 32'(mode_a), 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0);
    check("run_resumes", 32'(time_a), 32'h010001);

    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    check("edit_in_progress", 32'(time_a), 32'h010301);
    check("edit_mode", 32'(mode_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_mode", 32'(mode_a), 32'd0);
    check("midreset_time", 32'(time_a), 32'h000000);
    check("midreset_pre", 32'(time_b), 32'h235900);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("post_reset_tick", 32'(time_a), 32'h000001);
    check("post_reset_pre", 32'(time_b), 32'h235901);

`ifdef TIME_KEEPER_ALARM_EN
    step(1'b0, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (29) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("alarm_setup_mode", 32'(mode_a), 32'd0);
    check("alarm_setup_time", 32'(time_a), 32'h072900);
    repeat (59) step(1'b1, 1'b0, 1'b0);
    check("pre_alarm_time", 32'(time_a), 32'h072959);
    check("pre_alarm_off", 32'(alarm_a), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("alarm_time", 32'(time_a), 32'h073000);
    check("alarm_on", 32'(alarm_a), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("alarm_cleared", 32'(alarm_a), 32'd0);
    check("alarm_clear_mode", 32'(mode_a), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("mode_after_clear", 32'(mode_a), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter RESET_HOURS, default 0, binary hour loaded at reset (0..23).
REQ-002 SHALL have parameter RESET_MINUTES, default 0, binary minute loaded at reset (0..59).
REQ-003 SHALL have port i_Clock  in  1  system clock; all state on its rising edge.
REQ-004 SHALL have port i_Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_Enable_1Hz  in  1  one-cycle tick, once per second.
REQ-006 SHALL have port i_Button_Mode  in  1  debounced one-cycle pulse; advances mode.
REQ-007 SHALL have port i_Button_Inc  in  1  debounced one-cycle pulse; increments edited field.
REQ-008 SHALL have port o_Hours_Tens  out  2  BCD hour tens.
REQ-009 SHALL have port o_Hours_Ones  out  4  BCD hour ones.
REQ-010 SHALL have port o_Minutes_Tens  out  3  BCD minute tens.
REQ-011 SHALL have port o_Minutes_Ones  out  4  BCD minute ones.
REQ-012 SHALL have port o_Seconds_Tens  out  3  BCD second tens.
REQ-013 SHALL have port o_Seconds_Ones  out  4  BCD second ones.
REQ-014 SHALL have port o_Mode  out  3  current FSM state encoding.
REQ-015 SHALL have port o_Alarm  out  1  alarm active (present only under TIME_KEEPER_ALARM_EN).

Function
REQ-016 FSM states SHALL be RUN, SET_HOURS, SET_MINUTES (plus SET_ALARM_HOURS, SET_ALARM_MINUTES under macro).
REQ-017 i_Button_Mode SHALL advance RUN->SET_HOURS->SET_MINUTES->RUN (macro: SET_MINUTES->SET_ALARM_HOURS->SET_ALARM_MINUTES->RUN), one step per pulse.
REQ-018 In RUN, each i_Enable_1Hz SHALL increment time by one second; outputs update the cycle after the tick.
REQ-019 Rollover SHALL be seconds 59->00 carries to minutes, minutes 59->00 carries to hours, 23:59:59->00:00:00 in a single tick.
REQ-020 In any SET state, i_Enable_1Hz SHALL be ignored (time frozen).
REQ-021 In SET_HOURS, i_Button_Inc SHALL increment hours mod 24, no carry; in SET_MINUTES, minutes mod 60, no carry.
REQ-022 Transition SET_MINUTES->next state SHALL clear seconds to 00 on the same edge.
REQ-023 i_Button_Inc in RUN SHALL be ignored.
REQ-024 Mode and Inc asserted in the same cycle: Mode SHALL take effect, Inc SHALL be dropped.
REQ-025 All counters SHALL hold valid BCD; no output digit may exceed its range in any cycle.

Reset
REQ-026 On i_Reset_n low: state RUN, time RESET_HOURS:RESET_MINUTES:00 in BCD, o_Alarm 0, alarm time 00:00, immediately and independent of i_Clock.
REQ-027 Reset mid-edit SHALL discard edits in progress; first tick after release SHALL count normally.

Configuration
REQ-028 Macro TIME_KEEPER_ALARM_EN defined: alarm registers, two extra SET states, o_Alarm port present.
REQ-029 With macro: o_Alarm SHALL set the cycle after a RUN-mode tick producing HH:MM:00 equal to alarm HH:MM, and clear on next i_Button_Mode (that pulse SHALL NOT also advance mode).
REQ-030 Without macro: no alarm logic, no o_Alarm port, three-state FSM only; o_Mode encodings of shared states unchanged.

Structure
REQ-031 clock_pkg SHALL hold the mode-state encodings and BCD limit constants (24, 60).
REQ-032 Sub-module bcd_counter (two-digit BCD, parameterised modulus, inc and carry-out) SHALL be instantiated for seconds, minutes, hours (and alarm fields under macro).

Verification
REQ-033 Reset with defaults, 59 ticks -> 00:00:59; 60th tick -> 00:01:00.
REQ-034 Preload 23:59:58, 2 ticks -> 23:59:59 then 00:00:00.
REQ-035 Mode, Inc x25 in SET_HOURS -> hours 01; ticks during SET -> time unchanged.
REQ-036 Mode+Inc same cycle from RUN -> SET_HOURS, hours unchanged; exit SET_MINUTES at ss=37 -> ss=00.
REQ-037 Reset asserted in SET_MINUTES mid-cycle -> o_Mode RUN and time RESET values before next clock edge.
REQ-038 Macro on: alarm 07:30, time 07:29:59, one tick -> o_Alarm 1 next cycle; Mode pulse -> o_Alarm 0, o_Mode still RUN.
